// File: rtl/ysyx_22040383_mdu_pkg.sv
// rtl/ysyx_22040383_mdu_pkg.sv - op/state encodings and operand-signedness helpers for the MDU
package ysyx_22040383_mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // MUL keeps both operands unsigned: the low half of the product is sign-agnostic
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/ysyx_22040383_mdu_if.sv
// rtl/ysyx_22040383_mdu_if.sv - request/response handshake bundle between EX and the MDU
interface ysyx_22040383_mdu_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic            word_op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;
   logic            busy;

   modport master (
      output flush, in_valid, op, word_op, a, b, out_ready,
      input  in_ready, out_valid, res, busy
   );

   modport slave (
      input  flush, in_valid, op, word_op, a, b, out_ready,
      output in_ready, out_valid, res, busy
   );
endinterface

// File: rtl/ysyx_22040383_mdu_prep.sv
// rtl/ysyx_22040383_mdu_prep.sv - word extension, magnitudes, sign flags and special-case detect
module ysyx_22040383_mdu_prep
   import ysyx_22040383_mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      op,
   input  logic            word_op,
   output logic [XLEN-1:0] ext_a,
   output logic [XLEN-1:0] abs_a,
   output logic [XLEN-1:0] abs_b,
   output logic            neg_res,
   output logic            neg_rem,
   output logic            div_zero,
   output logic            sovf
);
   logic            sgn_a, sgn_b, sa, sb, a_min;
   logic [XLEN-1:0] ext_b;

   always_comb begin
      sgn_a = op_signed_a(op);
      sgn_b = op_signed_b(op);
      if (word_op) begin
         ext_a = {{(XLEN-32){sgn_a & a[31]}}, a[31:0]};
         ext_b = {{(XLEN-32){sgn_b & b[31]}}, b[31:0]};
         a_min = (ext_a == {{(XLEN-31){1'b1}}, 31'b0});
      end else begin
         ext_a = a;
         ext_b = b;
         a_min = (ext_a == {1'b1, {(XLEN-1){1'b0}}});
      end
      sa       = sgn_a & ext_a[XLEN-1];
      sb       = sgn_b & ext_b[XLEN-1];
      abs_a    = sa ? -ext_a : ext_a;
      abs_b    = sb ? -ext_b : ext_b;
      neg_res  = sa ^ sb;
      neg_rem  = sa;
      div_zero = op[2] && (ext_b == '0);
      // most-negative / -1 only exists for the signed divide/remainder ops
      sovf     = op[2] && sgn_b && a_min && (&ext_b);
   end
endmodule

// File: rtl/ysyx_22040383_mdu.sv
// rtl/ysyx_22040383_mdu.sv - iterative RV64M multiply/divide unit (early-out: YSYX_22040383_MDU_EARLY_OUT_EN)
module ysyx_22040383_mdu
   import ysyx_22040383_mdu_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter bit WORD_OPS = 1'b1
) (
   input logic               clk,
   input logic               rst,
   ysyx_22040383_mdu_if.slave io
);
   localparam int CW = $clog2(XLEN);
   localparam int W2 = 2 * XLEN;

   mdu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]      op_q, op_d;
   logic            word_q, word_d;
   logic [W2-1:0]   acc_q, acc_d;

   logic [XLEN-1:0] ext_a, abs_a, abs_b;
   logic            neg_res, neg_rem, div_zero, sovf, early;

   logic [W2-1:0]   mul_next, div_next, prod;
   logic [XLEN:0]   rem_sh;
   logic            rem_ge;
   logic [XLEN-1:0] rem_new, q_fix, r_fix, sel, result;

   ysyx_22040383_mdu_prep #(.XLEN(XLEN)) u_prep (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .word_op  (word_q),
      .ext_a    (ext_a),
      .abs_a    (abs_a),
      .abs_b    (abs_b),
      .neg_res  (neg_res),
      .neg_rem  (neg_rem),
      .div_zero (div_zero),
      .sovf     (sovf)
   );

`ifdef YSYX_22040383_MDU_EARLY_OUT_EN
   assign early = div_zero | sovf;
`else
   assign early = 1'b0;
`endif

   // Both algorithms consume one operand bit per cycle, MSB first, indexed by the counter
   always_comb begin
      mul_next = {acc_q[W2-2:0], 1'b0} + (abs_b[cnt_q] ? {{XLEN{1'b0}}, abs_a} : {W2{1'b0}});
      rem_sh   = {acc_q[XLEN-1:0], abs_a[cnt_q]};
      rem_ge   = rem_sh >= {1'b0, abs_b};
      rem_new  = rem_ge ? (rem_sh[XLEN-1:0] - abs_b) : rem_sh[XLEN-1:0];
      div_next = {acc_q[W2-2:XLEN], rem_ge, rem_new};
   end

   // acc holds the product, or {quotient, remainder} for divides
   always_comb begin
      prod  = neg_res ? -acc_q : acc_q;
      q_fix = neg_res ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
      r_fix = neg_rem ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      if (div_zero) begin
         q_fix = '1;
         r_fix = ext_a;
      end else if (sovf) begin
         q_fix = ext_a;
         r_fix = '0;
      end
      case (op_q)
         MDU_MUL:                        sel = prod[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: sel = prod[W2-1:XLEN];
         MDU_DIV, MDU_DIVU:              sel = q_fix;
         default:                        sel = r_fix;
      endcase
      result = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      word_d  = word_q;
      acc_d   = acc_q;
      res_d   = res_q;
      unique case (state_q)
         ST_IDLE: begin
            if (io.in_valid) begin
               a_d     = io.a;
               b_d     = io.b;
               op_d    = io.op;
               word_d  = io.word_op & WORD_OPS;
               cnt_d   = (io.word_op & WORD_OPS) ? CW'(31) : CW'(XLEN - 1);
               last_d  = 1'b0;
               acc_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (last_q || early) begin
               res_d   = result;
               cnt_d   = '0;
               last_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               acc_d = op_q[2] ? div_next : mul_next;
               if (cnt_q == '0) begin
                  last_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         ST_DONE: begin
            if (io.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // flush wins over both an offered op and a pending result
      if (io.flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         word_q  <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign io.in_ready  = (state_q == ST_IDLE);
   assign io.out_valid = (state_q == ST_DONE);
   assign io.busy      = (state_q != ST_IDLE);
   assign io.res       = res_q;
endmodule

// File: tb/tb_ysyx_22040383_mdu.sv
// tb/tb_ysyx_22040383_mdu.sv - directed vectors, handshake corner cases and random ops vs a reference model
module tb_ysyx_22040383_mdu;
   import ysyx_22040383_mdu_pkg::*;

`ifdef YSYX_22040383_MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ysyx_22040383_mdu_if #(.XLEN(64)) bus ();

   ysyx_22040383_mdu #(.XLEN(64), .WORD_OPS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  a32, b32, r32;
      longint       sa, sb, sr;
      logic         ovf;
      if (w) begin
         a32 = a[31:0];
         b32 = b[31:0];
         ovf = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
         r32 = '0;
         if (op == MDU_MUL) r32 = a32 * b32;
         else if (op == MDU_DIV) begin
            if (b32 == 0) r32 = '1;
            else if (ovf) r32 = a32;
            else r32 = $signed(a32) / $signed(b32);
         end else if (op == MDU_DIVU) begin
            if (b32 == 0) r32 = '1;
            else r32 = a32 / b32;
         end else if (op == MDU_REM) begin
            if (b32 == 0) r32 = a32;
            else if (ovf) r32 = '0;
            else r32 = $signed(a32) % $signed(b32);
         end else if (op == MDU_REMU) begin
            if (b32 == 0) r32 = a32;
            else r32 = a32 % b32;
         end
         return {{32{r32[31]}}, r32};
      end
      sa  = a;
      sb  = b;
      ovf = (a == MIN) && (b == ONES);
      case (op)
         MDU_MUL:    return a * b;
         MDU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         MDU_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
         MDU_MULHU:  begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
         MDU_DIV: begin
            if (b == 0) return ONES;
            if (ovf) return a;
            sr = sa / sb;
            return sr;
         end
         MDU_DIVU:   return (b == 0) ? ONES : a / b;
         MDU_REM: begin
            if (b == 0) return a;
            if (ovf) return '0;
            sr = sa % sb;
            return sr;
         end
         default:    return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ea, eb;
      logic        special;
      ea = w ? {{32{a[31] & ~op[0]}}, a[31:0]} : a;
      eb = w ? {{32{b[31] & ~op[0]}}, b[31:0]} : b;
      special = op[2] && ((eb == 0) ||
                (!op[0] && (eb == ONES) && (ea == (w ? 64'hFFFF_FFFF_8000_0000 : MIN))));
      if (special && EARLY) return 1;
      return (w ? 32 : 64) + 1;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return ONES;
         3: return MIN;
         4: return 64'hFFFF_FFFF_8000_0000;
         5: return {32'd0, $urandom()};
         6: return 64'($urandom_range(0, 20)) - 64'd10;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r, output int lat);
      int guard = 0;
      while (!bus.in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.op = op; bus.word_op = w; bus.a = a; bus.b = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r = bus.res;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   logic [63:0] r;
   int          lat;
   logic        seen;

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.op = '0; bus.word_op = 1'b0; bus.a = '0; bus.b = '0;

      vecs[0]  = '{MDU_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
      vecs[1]  = '{MDU_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      vecs[2]  = '{MDU_MULHSU, 1'b0, ONES, 64'd2, ONES, 65};
      vecs[3]  = '{MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      vecs[4]  = '{MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
      vecs[5]  = '{MDU_DIV,    1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, EARLY ? 1 : 33};
      vecs[6]  = '{MDU_DIVU,   1'b0, 64'd5, 64'd0, ONES, EARLY ? 1 : 65};
      vecs[7]  = '{MDU_REMU,   1'b0, 64'd5, 64'd0, 64'd5, EARLY ? 1 : 65};
      vecs[8]  = '{MDU_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
      vecs[9]  = '{MDU_REM,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 33};
      vecs[10] = '{MDU_DIV,    1'b0, MIN, ONES, MIN, EARLY ? 1 : 65};
      vecs[11] = '{MDU_REM,    1'b0, MIN, ONES, 64'd0, EARLY ? 1 : 65};
      vecs[12] = '{MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, EARLY ? 1 : 65};
      vecs[13] = '{MDU_REMU,   1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, EARLY ? 1 : 33};
      vecs[14] = '{MDU_MULH,   1'b0, MIN, MIN, 64'h4000_0000_0000_0000, 65};
      vecs[15] = '{MDU_DIVU,   1'b1, ONES, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_in_ready",  64'(bus.in_ready),  64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_busy",      64'(bus.busy),      64'd0);
      check("reset_res",       bus.res,            64'd0);

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, r, lat);
         check($sformatf("vec_res[%0d]", i), r, vecs[i].exp);
         check($sformatf("vec_lat[%0d]", i), 64'(lat), 64'(vecs[i].lat));
      end

      // result held while the consumer stalls; a pending request must not sneak in
      bus.op = MDU_MUL; bus.word_op = 1'b0; bus.a = 64'd3; bus.b = 64'd5;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.a = 64'd9;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int c = 0; c < 10; c++) begin
         check($sformatf("hold_res[%0d]", c), bus.res, 64'd15);
         check($sformatf("hold_in_ready[%0d]", c), 64'(bus.in_ready), 64'd0);
         @(posedge clk); #1;
      end
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("hs_out_valid", 64'(bus.out_valid), 64'd0);
      check("hs_no_accept", 64'(bus.busy),      64'd0);

      // flush mid-CALC with a new op offered
      bus.op = MDU_DIVU; bus.a = 64'hDEAD_BEEF_1234_5678; bus.b = 64'd77;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      bus.flush = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_busy",      64'(bus.busy),      64'd0);
      check("flush_in_ready",  64'(bus.in_ready),  64'd1);
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         seen |= bus.out_valid;
      end
      check("flush_no_result", 64'(seen), 64'd0);

      // flush in IDLE beats in_valid
      bus.flush = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_idle_no_accept", 64'(bus.busy), 64'd0);

      // reset mid-operation: res is nonzero from the hold test
      bus.op = MDU_MUL; bus.a = 64'd11; bus.b = 64'd13;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_busy",      64'(bus.busy),      64'd0);
      check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_mid_res",       bus.res,            64'd0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic        w;
         logic [63:0] a, b;
         op = 3'($urandom_range(0, 7));
         w  = ((op == MDU_MUL) || op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
         a  = pick();
         b  = pick();
         run_op(op, w, a, b, r, lat);
         check($sformatf("rand_res[%0d] op=%0d w=%0d a=%h b=%h", i, op, w, a, b), r, ref_res(op, w, a, b));
         check($sformatf("rand_lat[%0d]", i), 64'(lat), 64'(ref_lat(op, w, a, b)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
